// File: rtl/muldiv_ctrl_pkg.sv
// Package wrapping the shared muldiv encodings plus small op-decode helpers.
package muldiv_ctrl_pkg;

`include "muldiv_defs.vh"

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_defs.vh
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states, iteration count.
`ifndef MULDIV_DEFS_VH
`define MULDIV_DEFS_VH

localparam logic [1:0] OP_MULT  = 2'b00;
localparam logic [1:0] OP_MULTU = 2'b01;
localparam logic [1:0] OP_DIV   = 2'b10;
localparam logic [1:0] OP_DIVU  = 2'b11;

localparam int MULDIV_ITERS = 32;

typedef enum logic [1:0] {
  ST_IDLE = 2'd0,
  ST_CALC = 2'd1,
  ST_SIGN = 2'd2
} muldiv_state_e;

`endif

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             is_div_i,
`endif
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // Multiply: {hi,lo} holds partial product above the unconsumed multiplier bits.
  logic [WIDTH:0] sum;
  assign sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : {(WIDTH+1){1'b0}});

`ifdef MULDIV_DIV_EN
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  assign shifted = {hi_i, lo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, m_i};

  always_comb begin
    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
    if (is_div_i) begin
      hi_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ~diff[WIDTH]};
    end
  end
`else
  assign hi_o = sum[WIDTH:1];
  assign lo_o = {sum[0], lo_i[WIDTH-1:1]};
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide controller: 32 magnitude steps, one sign-fixup cycle.
// Divide is built only with MULDIV_DIV_EN; otherwise DIV/DIVU complete as a no-op.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(MULDIV_ITERS) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULDIV_ITERS - 1);

  muldiv_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] m_q;
  logic [1:0]       op_q;
  logic             neg_res_q;
  logic             done_q;
  logic             div_zero_q;
`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] op1_q;
  logic             neg_rem_q;
  logic             dz_q;
`endif

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic               mt_any;
  logic               accept;

  assign mt_any = mt_hi | mt_lo;
  assign accept = (state_q == ST_IDLE) && start && !flush && !mt_any;

  // The iteration works on magnitudes; signs are re-applied in ST_SIGN.
  assign mag_a = (is_signed_op(op) && op1[WIDTH-1]) ? (~op1 + 1'b1) : op1;
  assign mag_b = (is_signed_op(op) && op2[WIDTH-1]) ? (~op2 + 1'b1) : op2;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res_q ? (~prod + 1'b1) : prod;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  assign quo_fix = neg_res_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
  assign rem_fix = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
`endif

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
`ifdef MULDIV_DIV_EN
    .is_div_i (is_div_op(op_q)),
`endif
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .m_i      (m_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      m_q        <= '0;
      op_q       <= OP_MULT;
      neg_res_q  <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      op1_q      <= '0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mt_hi) hi_q <= op1;
          if (mt_lo) lo_q <= op1;
          if (accept) begin
            op_q      <= op;
            cnt_q     <= '0;
            neg_res_q <= is_signed_op(op) && (op1[WIDTH-1] ^ op2[WIDTH-1]);
            acc_hi_q  <= '0;
            if (is_div_op(op)) begin
`ifdef MULDIV_DIV_EN
              acc_lo_q  <= mag_a;
              m_q       <= mag_b;
              op1_q     <= op1;
              neg_rem_q <= is_signed_op(op) && op1[WIDTH-1];
              dz_q      <= (op2 == '0);
              state_q   <= ST_CALC;
`else
              // No divider: hold busy for a single cycle, then report done.
              state_q   <= ST_SIGN;
`endif
            end else begin
              acc_lo_q <= mag_b;
              m_q      <= mag_a;
              state_q  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) state_q <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          state_q <= ST_IDLE;
          if (!flush) begin
            done_q <= 1'b1;
            if (!is_div_op(op_q)) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else begin
`ifdef MULDIV_DIV_EN
              if (dz_q) begin
                hi_q       <= op1_q;
                lo_q       <= '1;
                div_zero_q <= 1'b1;
              end else begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
              end
`endif
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with a result scoreboard.
// Divide checks follow the MULDIV_DIV_EN build option.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int W       = 32;
  localparam int LAT_MUL = 34;
`ifdef MULDIV_DIV_EN
  localparam int LAT_DIV = 34;
`else
  localparam int LAT_DIV = 2;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         mt_hi = 1'b0;
  logic         mt_lo = 1'b0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  logic [2*W:0] exp_q[$];
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;
  int           n_tests = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .op1      (op1),
    .op2      (op2),
    .mt_hi    (mt_hi),
    .mt_lo    (mt_lo),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {div_zero, hi, lo}.
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [2*W-1:0] prev);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0]        p, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      OP_MULT:  begin p = sa * sb; return {1'b0, p}; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == OP_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          return {1'b0, sr[31:0], sq[31:0]};
        end
        uq = {32'b0, a} / {32'b0, b};
        ur = {32'b0, a} % {32'b0, b};
        return {1'b0, ur[31:0], uq[31:0]};
`else
        return {1'b0, prev};
`endif
      end
    endcase
  endfunction

  task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W:0] exp, input int lat,
                       input bit disturb);
    logic [2*W:0] got;
    int seen;
    exp_q.push_back(exp);
    @(negedge clk); start = 1'b1; op = o; op1 = a; op2 = b;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) @(negedge clk);
      if (disturb && c == 5) begin
        start = 1'b1; mt_hi = 1'b1; mt_lo = 1'b1; op = OP_MULTU; op1 = 32'hDEAD_BEEF;
      end
      if (disturb && c == 6) begin
        start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
      end
      check($sformatf("%s_busy_done_c%0d", name, c), 65'({busy, done}),
            (c < lat) ? 65'd2 : 65'd1);
    end
    got = exp_q.pop_front();
    check($sformatf("%s_result", name), {div_zero, hi, lo}, got);
    model_hi = got[63:32];
    model_lo = got[31:0];
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check($sformatf("%s_quiet_after", name), 65'(seen), 65'd0);
  endtask

  task automatic abort_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int at_c, input bit use_reset);
    int seen;
    @(negedge clk); start = 1'b1; op = o; op1 = a; op2 = b;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c < at_c; c++) @(negedge clk);
    check($sformatf("%s_busy_before", name), 65'(busy), 65'd1);
    if (use_reset) reset = 1'b1;
    else flush = 1'b1;
    @(negedge clk); reset = 1'b0; flush = 1'b0;
    if (use_reset) begin
      model_hi = '0;
      model_lo = '0;
    end
    check($sformatf("%s_idle_after", name), 65'({busy, done}), 65'd0);
    check($sformatf("%s_hilo", name), {div_zero, hi, lo}, {1'b0, model_hi, model_lo});
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check($sformatf("%s_no_done", name), 65'(seen), 65'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ctrl", 65'({busy, done, div_zero}), 65'd0);
    check("reset_hilo", 65'({hi, lo}), 65'd0);

    // mt_lo beats a simultaneous start in IDLE
    @(negedge clk); mt_lo = 1'b1; start = 1'b1; op = OP_MULTU; op1 = 32'h1234_5678; op2 = 32'd5;
    @(negedge clk); mt_lo = 1'b0; start = 1'b0;
    model_lo = 32'h1234_5678;
    check("mt_lo", 65'({busy, hi, lo}), 65'({1'b0, model_hi, model_lo}));
    @(negedge clk);
    check("mt_lo_start_dropped", 65'({busy, done}), 65'd0);

    @(negedge clk); mt_hi = 1'b1; op1 = 32'hA5A5_0F0F;
    @(negedge clk); mt_hi = 1'b0;
    model_hi = 32'hA5A5_0F0F;
    check("mt_hi", 65'({busy, hi, lo}), 65'({1'b0, model_hi, model_lo}));

    // flush together with start in IDLE drops the start
    @(negedge clk); flush = 1'b1; start = 1'b1; op = OP_MULT; op1 = 32'd3; op2 = 32'd4;
    @(negedge clk); flush = 1'b0; start = 1'b0;
    check("flush_start_idle", 65'({busy, done}), 65'd0);
    check("flush_idle_hilo", 65'({hi, lo}), 65'({model_hi, model_lo}));

    // Multiply, with a second start and mt_* pulsed mid-operation
    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}, LAT_MUL, 1'b1);
    do_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7,
          {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, LAT_MUL, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ro = (i % 2 == 0) ? OP_MULT : OP_MULTU;
      ra = $urandom;
      rb = $urandom;
      do_op($sformatf("mul_rand%0d", i), ro, ra, rb, model(ro, ra, rb, {model_hi, model_lo}),
            LAT_MUL, 1'b0);
    end

    abort_op("mult_flush_c10", OP_MULT, 32'hFFFF_FFFB, 32'd9, 10, 1'b0);

`ifdef MULDIV_DIV_EN
    do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
          {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, LAT_DIV, 1'b0);
    do_op("divu_by0", OP_DIVU, 32'd100, 32'd0,
          {1'b1, 32'h0000_0064, 32'hFFFF_FFFF}, LAT_DIV, 1'b0);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          {1'b0, 32'h0000_0000, 32'h8000_0000}, LAT_DIV, 1'b0);
    do_op("div_neg_by0", OP_DIV, 32'hFFFF_FFF0, 32'd0,
          {1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF}, LAT_DIV, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ro = (i % 2 == 0) ? OP_DIV : OP_DIVU;
      ra = $urandom;
      rb = (i < 2) ? $urandom_range(1, 1000) : $urandom;
      do_op($sformatf("div_rand%0d", i), ro, ra, rb, model(ro, ra, rb, {model_hi, model_lo}),
            LAT_DIV, 1'b0);
    end
    abort_op("div_reset_c20", OP_DIV, 32'd1000, 32'd7, 20, 1'b1);
`else
    do_op("divu_nodiv", OP_DIVU, 32'd10, 32'd3, {1'b0, model_hi, model_lo}, LAT_DIV, 1'b0);
    do_op("div_nodiv", OP_DIV, 32'hFFFF_FFF9, 32'd0, {1'b0, model_hi, model_lo}, LAT_DIV, 1'b0);
    abort_op("mult_reset_c20", OP_MULT, 32'd1000, 32'd7, 20, 1'b1);
`endif

    // Recovery after the mid-operation reset
    do_op("mult_after_reset", OP_MULT, 32'h0001_0000, 32'hFFFF_0000,
          model(OP_MULT, 32'h0001_0000, 32'hFFFF_0000, {model_hi, model_lo}), LAT_MUL, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand, HI and LO width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  in  1  request to begin the operation selected by op.
REQ-005 SHALL have port op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port op1  in  WIDTH  operand rs (dividend or multiplicand); also data for mt_hi and mt_lo.
REQ-007 SHALL have port op2  in  WIDTH  operand rt (divisor or multiplier).
REQ-008 SHALL have port mt_hi  in  1  write op1 to HI.
REQ-009 SHALL have port mt_lo  in  1  write op1 to LO.
REQ-010 SHALL have port flush  in  1  abort the operation in progress.
REQ-011 SHALL have port busy  out  1  pipeline stall request.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port div_zero  out  1  divide-by-zero flag, valid with done.
REQ-014 SHALL have port hi  out  WIDTH  HI register.
REQ-015 SHALL have port lo  out  WIDTH  LO register.

Function
REQ-016 SHALL implement an FSM with states IDLE, CALC and SIGN.
- IDLE -> CALC on accepted start.
- CALC -> SIGN after 32 iterations.
- SIGN -> IDLE unconditionally.
REQ-017 SHALL accept start only in IDLE with mt_hi=mt_lo=0; op1, op2 and op are latched at the accepting edge (cycle 0).
REQ-018 SHALL run CALC for exactly 32 cycles (cycles 1..32), performing one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle on magnitudes.
REQ-019 SHALL in SIGN (cycle 33) apply sign correction for signed ops and write hi/lo at the end of cycle 33.
- Signed ops: product sign = XOR of operand signs; quotient sign = XOR of operand signs; remainder sign = dividend sign.
REQ-020 SHALL drive busy = (state != IDLE), i.e. high in cycles 1..33, and drive done high in cycle 34 only.
REQ-021 SHALL place the multiply result as hi = product[63:32], lo = product[31:0]; divide as lo = quotient, hi = remainder.
REQ-022 SHALL, when the divisor is 0, set lo = 0xFFFFFFFF, hi = op1 and div_zero = 1 with done; div_zero SHALL be 0 otherwise.
REQ-023 SHALL return lo = 0x80000000, hi = 0 for DIV 0x80000000 / 0xFFFFFFFF.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL, in IDLE, write op1 to HI (mt_hi) and/or LO (mt_lo) at that edge; in that cycle mt_hi/mt_lo SHALL take priority over start, and the start SHALL be dropped.
REQ-026 SHALL ignore mt_hi and mt_lo while busy.
REQ-027 SHALL, on flush while busy, go to IDLE next edge with hi/lo unchanged and no done pulse; flush in IDLE SHALL have no effect; flush with start in IDLE SHALL drop the start.

Reset
REQ-028 SHALL on reset go to IDLE and clear hi, lo, busy, done, div_zero and the iteration counter to 0, including mid-operation; reset SHALL override flush, start and mt_*.

Configuration
REQ-029 SHALL compile divide support only when macro MULDIV_DIV_EN is defined.
REQ-030 SHALL, without MULDIV_DIV_EN, accept DIV/DIVU as follows:
- busy held 1 cycle, then done pulse in cycle 2;
- hi/lo unchanged and div_zero = 0;
- no divider logic synthesized.
Multiply behaviour SHALL be identical with and without the macro.

Structure
REQ-031 SHALL take op encodings, FSM state encodings and the iteration count constant (32) from shared include muldiv_defs.vh.
REQ-032 SHALL place the single-iteration combinational step (add/subtract, shift, restore) in sub-module muldiv_step; muldiv_ctrl holds the FSM, counter and HI/LO/accumulator registers.

Verification
REQ-033 Bench SHALL check: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; busy cycles 1..33; done in cycle 34 only.
REQ-034 Bench SHALL check: MULT 0xFFFFFFFD (-3) x 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-035 Bench SHALL check: DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 100 / 0 -> lo = 0xFFFFFFFF, hi = 0x00000064, div_zero = 1.
REQ-036 Bench SHALL check: start in cycle 0, second start in cycle 5 -> ignored, single done in cycle 34; mt_lo with op1 = 0x12345678 in IDLE -> lo = 0x12345678 next cycle.
REQ-037 Bench SHALL check: flush in cycle 10 of a MULT -> hi/lo keep prior values and no done; reset in cycle 20 of a DIV -> next cycle busy = 0, hi = lo = 0, no done.
REQ-038 Bench SHALL check: build without MULDIV_DIV_EN, DIVU 10 / 3 -> done in cycle 2 and hi/lo unchanged.
